// File: rtl/beam_cmp_pkg.sv
// beam_cmp_pkg: shared state encoding and instruction field positions for the beam comparator sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a. The watchdog build option is BEAM_CMP_TIMEOUT_EN.
package beam_cmp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LDQ  = 3'd1,
      ST_LDM  = 3'd2,
      ST_ARM  = 3'd3,
      ST_EVAL = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   // IR2 (mask word) fields
   localparam int IR2_BFD     = 15;
   localparam int IR2_MASK_HI = 14;
   localparam int IR2_MASK_LO = 1;
   localparam int IR2_SKIP    = 0;

   // IR1 (position word) target position field
   localparam int IR1_POS_HI = 15;
   localparam int IR1_POS_LO = 1;

   // Watchdog limit for the default counter width; the counter itself saturates at all-ones
   localparam int                    TMO_W_DFLT = 16;
   localparam logic [TMO_W_DFLT-1:0] TMO_MAX    = '1;

endpackage

// File: rtl/beam_cmp_seq_if.sv
// beam_cmp_seq_if: instruction handshake, comparator bank bus and status signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd_valid/cmd_ready; the slave modport is the sequencer, master is the fetch/bank side.
interface beam_cmp_seq_if #(
   parameter int POS_W = 15,
   parameter int IR_W  = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [IR_W-1:0]  cmd_ir1;
   logic [IR_W-1:0]  cmd_ir2;
   logic             beam_tick;
   logic             blit_busy;
   logic             cmp_co;
   logic [POS_W-1:0] cmp_db;
   logic             cmp_lq;
   logic             cmp_lm;
   logic             cmp_c1;
   logic             busy;
   logic             wait_done;
   logic             skip_valid;
   logic             skip_take;
   logic             tmo_err;

   modport slave (
      input  cmd_valid, cmd_ir1, cmd_ir2, beam_tick, blit_busy, cmp_co,
      output cmd_ready, cmp_db, cmp_lq, cmp_lm, cmp_c1, busy,
             wait_done, skip_valid, skip_take, tmo_err
   );

   modport master (
      output cmd_valid, cmd_ir1, cmd_ir2, beam_tick, blit_busy, cmp_co,
      input  cmd_ready, cmp_db, cmp_lq, cmp_lm, cmp_c1, busy,
             wait_done, skip_valid, skip_take, tmo_err
   );
endinterface

// File: rtl/beam_cmp_tmo.sv
// beam_cmp_tmo: WAIT watchdog counter, cleared on accept, counts beam ticks, saturates at all-ones.
// Latency: sat_o rises the cycle after the increment that reaches all-ones.
// Backpressure: none; only built with BEAM_CMP_TIMEOUT_EN.
module beam_cmp_tmo #(
   parameter int TMO_W = 16
) (
   input  logic main_clk,
   input  logic main_rst,
   input  logic clr_i,
   input  logic inc_i,
   output logic sat_o
);
   logic [TMO_W-1:0] cnt_q, cnt_d;

   assign sat_o = &cnt_q;

   // Next count: clear wins, then increment until saturated
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !sat_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge main_clk or posedge main_rst) begin
      if (main_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/beam_cmp_seq.sv
// beam_cmp_seq: WAIT/SKIP sequencer loading and sampling the bit-sliced beam comparator bank.
// Latency: accept to DONE >= 5 cycles (LDQ, LDM, ARM, EVAL, DONE); C1 is combinational on beam_tick in ARM.
// Backpressure: cmd_ready only in IDLE. Optional watchdog under BEAM_CMP_TIMEOUT_EN.
module beam_cmp_seq
   import beam_cmp_pkg::*;
#(
   parameter int POS_W = 15,
   parameter int IR_W  = 16,
   parameter int TMO_W = 16
) (
   input logic           main_clk,
   input logic           main_rst,
   beam_cmp_seq_if.slave seq_if
);
   state_t           state_q, state_d;
   logic [IR_W-1:0]  ir2_q, ir2_d;
   logic [POS_W-1:0] db_q, db_d;
   logic             hit_q, hit_d;
   logic             tmo_q, tmo_d;
   logic             accept;
   logic             is_skip;
   logic             hit_now;
   logic             tmo_abort;

   assign accept  = (state_q == ST_IDLE) && seq_if.cmd_valid;
   assign is_skip = ir2_q[IR2_SKIP];
   // BFD set means the blitter state does not gate the comparison
   assign hit_now = seq_if.cmp_co && (ir2_q[IR2_BFD] || !seq_if.blit_busy);

`ifdef BEAM_CMP_TIMEOUT_EN
   logic tmo_sat;
   logic tmo_inc;

   assign tmo_inc = seq_if.beam_tick && !is_skip &&
                    ((state_q == ST_ARM) || (state_q == ST_EVAL));

   beam_cmp_tmo #(.TMO_W(TMO_W)) u_tmo (
      .main_clk (main_clk),
      .main_rst (main_rst),
      .clr_i    (accept),
      .inc_i    (tmo_inc),
      .sat_o    (tmo_sat)
   );

   assign tmo_abort      = tmo_sat && !is_skip;
   assign seq_if.tmo_err = (state_q == ST_DONE) && tmo_q;
`else
   assign tmo_abort      = 1'b0;
   assign seq_if.tmo_err = 1'b0;
`endif

   // Next state, bus/result registers and strobes
   always_comb begin
      state_d           = state_q;
      ir2_d             = ir2_q;
      db_d              = db_q;
      hit_d             = hit_q;
      tmo_d             = tmo_q;
      seq_if.cmd_ready  = 1'b0;
      seq_if.busy       = 1'b1;
      seq_if.cmp_lq     = 1'b0;
      seq_if.cmp_lm     = 1'b0;
      seq_if.cmp_c1     = 1'b0;
      seq_if.wait_done  = 1'b0;
      seq_if.skip_valid = 1'b0;
      seq_if.skip_take  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            seq_if.cmd_ready = 1'b1;
            seq_if.busy      = 1'b0;
            if (accept) begin
               ir2_d   = seq_if.cmd_ir2;
               // Position goes onto the bus now so it is stable for the whole LDQ cycle
               db_d    = seq_if.cmd_ir1[IR1_POS_HI:IR1_POS_LO];
               hit_d   = 1'b0;
               tmo_d   = 1'b0;
               state_d = ST_LDQ;
            end
         end
         ST_LDQ: begin
            seq_if.cmp_lq = 1'b1;
            // Top vertical bit is never maskable
            db_d    = {1'b1, ir2_q[IR2_MASK_HI:IR2_MASK_LO]};
            state_d = ST_LDM;
         end
         ST_LDM: begin
            seq_if.cmp_lm = 1'b1;
            state_d       = ST_ARM;
         end
         ST_ARM: begin
            if (tmo_abort) begin
               tmo_d   = 1'b1;
               state_d = ST_DONE;
            end else if (seq_if.beam_tick) begin
               seq_if.cmp_c1 = 1'b1;
               state_d       = ST_EVAL;
            end
         end
         ST_EVAL: begin
            // Carry chain has had one full cycle to settle since C1
            hit_d = hit_now;
            if (is_skip || hit_now) begin
               state_d = ST_DONE;
            end else if (tmo_abort) begin
               tmo_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               state_d = ST_ARM;
            end
         end
         ST_DONE: begin
            seq_if.wait_done  = !is_skip && !tmo_q;
            seq_if.skip_valid = is_skip;
            seq_if.skip_take  = is_skip && hit_q;
            state_d           = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign seq_if.cmp_db = db_q;

   // State and latched instruction registers
   always_ff @(posedge main_clk or posedge main_rst) begin
      if (main_rst) begin
         state_q <= ST_IDLE;
         ir2_q   <= '0;
         db_q    <= '0;
         hit_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ir2_q   <= ir2_d;
         db_q    <= db_d;
         hit_q   <= hit_d;
         tmo_q   <= tmo_d;
      end
   end
endmodule
